byte_word_packer: RTL
=====================

// Module: byte_word_packer
// PURPOSE
// - Sits directly downstream of the 8-bit two-stage data-processing pipeline and consumes its data_out/valid_out.
// - Packs consecutive bytes into 16-bit words and buffers them in a small FIFO.
// - Presents the words on a valid/ready interface.
// - The upstream stage has no backpressure, so this block absorbs bursts and flags loss via a sticky overflow bit.
// PARAMETERS
// DEPTH    4                   FIFO entries (power of 2, >=2)
// AW       $clog2(DEPTH)       FIFO pointer width (derived, not overridable)
// PORTS
// clk           in   1     single clock, rising edge
// rst_n         in   1     asynchronous active-low reset
// byte_in       in   8     byte from upstream pipeline
// byte_valid    in   1     byte_in qualifier, one byte per asserted cycle
// flush         in   1     pulse: emit any held odd byte as a partial word
// word_out      out  16    packed word, first byte in [7:0], second in [15:8]
// word_partial  out  1     word_out carries one byte only ([15:8]=8'h00)
// word_valid    out  1     FIFO non-empty
// word_ready    in   1     consumer accepts word when word_valid&word_ready
// level         out  AW+1  FIFO occupancy, 0..DEPTH
// overflow      out  1     sticky: a word was dropped because FIFO full
// clr_overflow  in   1     synchronous clear of overflow
// BEHAVIOUR
// - Reset (async, rst_n=0): pack state EMPTY, holding byte 8'h00, FIFO pointers 0.
//   Outputs: word_valid=0, word_out=16'h0000, word_partial=0, level=0, overflow=0.
// - Pack FSM, 2 states:
//   EMPTY + byte_valid & !flush -> store byte_in in hold, -> HALF.
//   EMPTY + byte_valid & flush  -> push {8'h00,byte_in}, partial=1, stay EMPTY.
//   EMPTY + flush alone         -> no-op.
//   HALF + byte_valid           -> push {byte_in,hold}, partial=0, -> EMPTY (flush ignored same cycle).
//   HALF + flush & !byte_valid  -> push {8'h00,hold}, partial=1, -> EMPTY.
//   HALF + idle                 -> hold indefinitely.
// - Latency: word_valid rises the cycle after the completing byte/flush (1 clk), when FIFO was empty.
// - FIFO: first-word-fall-through registered storage, 17-bit entries {partial, word}.
//   word_out/word_partial driven from head entry, stable while word_valid&!word_ready.
//   word_out is don't-care when word_valid=0; it must hold last value, never X.
// - Pop on word_valid&word_ready. Push and pop in same cycle always legal.
//   When full, a simultaneous pop frees the slot, so the push succeeds and level is unchanged.
// - Full with push and no pop: word dropped, FIFO unchanged, overflow<=1.
//   FSM still returns to EMPTY, so the held byte is lost too.
// - overflow: set wins over clr_overflow in the same cycle.
// - level = wr_ptr - rd_ptr using AW+1-bit pointers. Pointer wrap at 2*DEPTH is natural modulo.
//   full when MSBs differ and low bits are equal.
// - word_ready with word_valid=0 is ignored; no underflow.
// - rst_n assertion mid-operation: all state cleared immediately, buffered and held data discarded.
// STRUCTURE
// - Shared package dp_pkg: BYTE_W=8, WORD_W=16, pack_state_t enum {PK_EMPTY, PK_HALF}.
// - Sub-module sync_fifo_fwft (params WIDTH=17, DEPTH), reusable elsewhere in the datapath.
// - Top: pack FSM + hold register + overflow flag.
// TESTING
// 1 Reset: drive rst_n=0 mid-burst -> all outputs 0 next sample, level=0, FSM EMPTY.
// 2 Bytes 8'hA1,8'hB2 on consecutive cycles, word_ready=1 -> word_out=16'hB2A1, partial=0, word_valid 1 clk after 8'hB2.
// 3 Byte 8'h5C then flush 3 cycles later -> word_out=16'h005C, word_partial=1; flush in EMPTY produces nothing.
// 4 word_ready=0, 10 bytes (DEPTH=4) -> 4 words held, level=4, 5th word dropped, overflow=1; clr_overflow -> 0.
// 5 Full FIFO, word_ready=1 on the same cycle a word completes -> pop and push both occur, level stays 4, overflow stays 0.
// 6 Random bytes/flush/ready for 10k cycles vs scoreboard -> in-order words, no loss unless overflow set, level matches model.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared datapath types and widths for the byte-to-word packing stage.
package dp_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned ENTRY_W = WORD_W + 1;

    typedef enum logic {
        PK_EMPTY = 1'b0,
        PK_HALF  = 1'b1
    } pack_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head output that holds its
// last value while empty. Pointers carry one extra bit to tell full from empty.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = !empty && rd_ready;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign do_push  = wr_en && (!full || do_pop);
    assign rd_valid = !empty;
    assign rd_data  = dout_q;
    assign level    = wr_ptr_q - rd_ptr_q;

    // Next pointers and the entry that will sit at the head after this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        dout_d   = dout_q;
        if (wr_ptr_d != rd_ptr_d) begin
            if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                dout_d = wr_data;
            end else begin
                dout_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Storage, pointers and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/byte_word_packer.sv
// Packs upstream bytes into 16-bit words, buffers them and flags lost words.
module byte_word_packer
    import dp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    input  logic                     flush,
    output logic [15:0]              word_out,
    output logic                     word_partial,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    pack_state_t         state_q, state_d;
    logic [BYTE_W-1:0]   hold_q, hold_d;
    logic                overflow_q, overflow_d;
    logic                push_c;
    logic [ENTRY_W-1:0]  push_data_c;
    logic [ENTRY_W-1:0]  head;
    logic                fifo_full;
    logic                drop_c;

    // Pack decision: which word (if any) completes this cycle.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        push_c      = 1'b0;
        push_data_c = '0;
        case (state_q)
            PK_EMPTY: begin
                if (byte_valid) begin
                    if (flush) begin
                        push_c      = 1'b1;
                        push_data_c = {1'b1, 8'h00, byte_in};
                    end else begin
                        hold_d  = byte_in;
                        state_d = PK_HALF;
                    end
                end
            end
            PK_HALF: begin
                if (byte_valid) begin
                    push_c      = 1'b1;
                    push_data_c = {1'b0, byte_in, hold_q};
                    state_d     = PK_EMPTY;
                end else if (flush) begin
                    push_c      = 1'b1;
                    push_data_c = {1'b1, 8'h00, hold_q};
                    state_d     = PK_EMPTY;
                end
            end
            default: begin
                state_d = PK_EMPTY;
            end
        endcase
    end

    // A push into a full FIFO with no concurrent pop is lost; set beats clear.
    assign drop_c = push_c && fifo_full && !(word_valid && word_ready);

    always_comb begin
        overflow_d = overflow_q;
        if (drop_c) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Pack state, hold byte and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PK_EMPTY;
            hold_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (push_c),
        .wr_data  (push_data_c),
        .rd_ready (word_ready),
        .rd_data  (head),
        .rd_valid (word_valid),
        .full     (fifo_full),
        .level    (level)
    );

    assign word_out     = head[WORD_W-1:0];
    assign word_partial = head[WORD_W];
    assign overflow     = overflow_q;

endmodule
